// File: rtl/ipv4_pkg.sv
// Shared constants, state encoding and header-word types for the IPv4 header
// capture front end.
package ipv4_pkg;

    localparam logic [3:0] IPV4_VERSION = 4'd4;
    localparam logic [3:0] IHL_MIN      = 4'd5;
    localparam logic [3:0] IHL_MAX      = 4'd6;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_VER  = 2'd1;
    localparam logic [1:0] ERR_IHL  = 2'd2;
    localparam logic [1:0] ERR_RUNT = 2'd3;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_HDR  = 3'd1;
    localparam logic [2:0] ST_HOLD = 3'd2;
    localparam logic [2:0] ST_SKIP = 3'd3;
    localparam logic [2:0] ST_DROP = 3'd4;

    localparam int IDX_W     = 5;
    localparam int NUM_WORDS = 6;

    typedef logic [NUM_WORDS-1:0][31:0] hdr_words_t;

    // Byte index of the final header byte for a given IHL (in 32-bit words).
    function automatic logic [IDX_W-1:0] last_hdr_idx(input logic [3:0] ihl);
        return IDX_W'({ihl, 2'b00} - 6'd1);
    endfunction

endpackage

// File: rtl/ipv4_hdr_word_packer.sv
// Shadow header buffer: places each stream byte into word idx/4, lane 3-idx%4,
// and exposes the next-state words so the top can commit the final byte directly.
module ipv4_hdr_word_packer
    import ipv4_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic             clr_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [7:0]       data_i,
    output hdr_words_t       words_nxt_o,
    output logic [7:0]       len_hi_o
);

    hdr_words_t words_q;
    hdr_words_t words_d;

    // Byte-lane decode; the option word is cleared when a capture starts.
    always_comb begin
        words_d = words_q;
        for (int w = 0; w < NUM_WORDS; w++) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_en_i && (idx_i == IDX_W'(4 * w + b))) begin
                    words_d[w][8*(3-b) +: 8] = data_i;
                end else if (clr_i && (w == NUM_WORDS - 1)) begin
                    words_d[w][8*(3-b) +: 8] = 8'h00;
                end else begin
                    words_d[w][8*(3-b) +: 8] = words_q[w][8*(3-b) +: 8];
                end
            end
        end
    end

    // Shadow word storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_q <= '0;
        end else begin
            words_q <= words_d;
        end
    end

    assign words_nxt_o = words_d;
    assign len_hi_o    = words_q[0][15:8];

endmodule

// File: rtl/ipv4_hdr_capture.sv
// Byte-stream IPv4 header capture: assembles ih1..ih6, sanity-checks version,
// IHL and length, and presents the header under a valid/ack handshake.
module ipv4_hdr_capture
    import ipv4_pkg::*;
#(
    parameter int unsigned MAX_IHL = 32'(IHL_MAX),
    parameter int unsigned MIN_IHL = 32'(IHL_MIN)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_sop,
    input  logic        rx_eop,
    output logic        rx_ready,
    output logic [31:0] ih1,
    output logic [31:0] ih2,
    output logic [31:0] ih3,
    output logic [31:0] ih4,
    output logic [31:0] ih5,
    output logic [31:0] ih6,
    output logic [3:0]  hdr_ihl,
    output logic        hdr_valid,
    input  logic        hdr_ack,
    output logic        hdr_err,
    output logic [1:0]  err_code,
    output logic [15:0] pkt_count
);

    localparam logic [3:0] IHL_HI = 4'(MAX_IHL);
    localparam logic [3:0] IHL_LO = 4'(MIN_IHL);

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       ihl_q, ihl_d;
    logic             eop_last_q, eop_last_d;
    logic             rx_ready_q, rx_ready_d;
    hdr_words_t       ih_q, ih_d;
    logic [3:0]       hdr_ihl_q, hdr_ihl_d;
    logic             hdr_valid_q, hdr_valid_d;
    logic             hdr_err_q, hdr_err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [15:0]      pkt_count_q, pkt_count_d;

    logic             take_s;
    logic             start_s;
    logic             wr_en_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic [1:0]       fault_s;
    logic [7:0]       len_hi_s;
    logic [15:0]      tot_len_s;
    logic [15:0]      min_len_s;
    hdr_words_t       words_nxt_s;

    assign take_s    = rx_valid && rx_ready_q;
    assign start_s   = take_s && rx_sop;
    assign wr_en_s   = start_s || (take_s && (state_q == ST_HDR));
    assign wr_idx_s  = start_s ? {IDX_W{1'b0}} : idx_q;
    assign tot_len_s = {len_hi_s, rx_data};
    assign min_len_s = {10'd0, ihl_q, 2'b00};

    ipv4_hdr_word_packer u_packer (
        .clk         (clk),
        .rst_n       (reset),
        .wr_en_i     (wr_en_s),
        .clr_i       (start_s),
        .idx_i       (wr_idx_s),
        .data_i      (rx_data),
        .words_nxt_o (words_nxt_s),
        .len_hi_o    (len_hi_s)
    );

    // Per-byte sanity check; a sop byte is always index 0 of a fresh capture.
    always_comb begin
        fault_s = ERR_NONE;
        if (start_s) begin
            if (rx_data[7:4] != IPV4_VERSION) begin
                fault_s = ERR_VER;
            end else if ((rx_data[3:0] < IHL_LO) || (rx_data[3:0] > IHL_HI)) begin
                fault_s = ERR_IHL;
            end else if (rx_eop) begin
                fault_s = ERR_RUNT;
            end else begin
                fault_s = ERR_NONE;
            end
        end else if (take_s && (state_q == ST_HDR)) begin
            if ((idx_q == IDX_W'(3)) && (tot_len_s < min_len_s)) begin
                fault_s = ERR_RUNT;
            end else if (rx_eop && (idx_q != last_hdr_idx(ihl_q))) begin
                fault_s = ERR_RUNT;
            end else begin
                fault_s = ERR_NONE;
            end
        end else begin
            fault_s = ERR_NONE;
        end
    end

    // Capture FSM and output next-state.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ihl_d       = ihl_q;
        eop_last_d  = eop_last_q;
        ih_d        = ih_q;
        hdr_ihl_d   = hdr_ihl_q;
        hdr_err_d   = 1'b0;
        err_code_d  = err_code_q;
        pkt_count_d = pkt_count_q;
        case (state_q)
            ST_HOLD: begin
                if (hdr_ack) begin
                    state_d     = eop_last_q ? ST_IDLE : ST_SKIP;
                    pkt_count_d = pkt_count_q + 16'd1;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_IDLE, ST_HDR, ST_SKIP, ST_DROP: begin
                if (fault_s != ERR_NONE) begin
                    hdr_err_d  = 1'b1;
                    err_code_d = fault_s;
                    idx_d      = {IDX_W{1'b0}};
                    state_d    = rx_eop ? ST_IDLE : ST_DROP;
                end else if (start_s) begin
                    state_d = ST_HDR;
                    idx_d   = IDX_W'(1);
                    ihl_d   = rx_data[3:0];
                end else if (take_s && (state_q == ST_HDR)) begin
                    if (idx_q == last_hdr_idx(ihl_q)) begin
                        state_d    = ST_HOLD;
                        idx_d      = {IDX_W{1'b0}};
                        eop_last_d = rx_eop;
                        ih_d       = words_nxt_s;
                        hdr_ihl_d  = ihl_q;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (take_s && rx_eop && (state_q != ST_IDLE)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        hdr_valid_d = (state_d == ST_HOLD);
        rx_ready_d  = (state_d != ST_HOLD);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= {IDX_W{1'b0}};
            ihl_q       <= 4'd0;
            eop_last_q  <= 1'b0;
            rx_ready_q  <= 1'b0;
            ih_q        <= '0;
            hdr_ihl_q   <= 4'd0;
            hdr_valid_q <= 1'b0;
            hdr_err_q   <= 1'b0;
            err_code_q  <= ERR_NONE;
            pkt_count_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ihl_q       <= ihl_d;
            eop_last_q  <= eop_last_d;
            rx_ready_q  <= rx_ready_d;
            ih_q        <= ih_d;
            hdr_ihl_q   <= hdr_ihl_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_err_q   <= hdr_err_d;
            err_code_q  <= err_code_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign ih1       = ih_q[0];
    assign ih2       = ih_q[1];
    assign ih3       = ih_q[2];
    assign ih4       = ih_q[3];
    assign ih5       = ih_q[4];
    assign ih6       = ih_q[5];
    assign hdr_ihl   = hdr_ihl_q;
    assign hdr_valid = hdr_valid_q;
    assign hdr_err   = hdr_err_q;
    assign err_code  = err_code_q;
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_ipv4_hdr_capture.sv
// Scoreboard bench for ipv4_hdr_capture: directed packets push expected headers
// and error codes; a negedge monitor pops and compares whenever the DUT reports.
module tb_ipv4_hdr_capture;

    typedef struct packed {
        logic [3:0]       ihl;
        logic [5:0][31:0] w;
    } exp_hdr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_sop = 1'b0;
    logic        rx_eop = 1'b0;
    logic        rx_ready;
    logic [31:0] ih1, ih2, ih3, ih4, ih5, ih6;
    logic [3:0]  hdr_ihl;
    logic        hdr_valid;
    logic        hdr_ack;
    logic        hdr_err;
    logic [1:0]  err_code;
    logic [15:0] pkt_count;

    logic        ack_drv = 1'b0;
    logic        stray_ack = 1'b0;
    int          ack_delay = 0;
    int          ack_cnt = 0;
    int          checks = 0;
    int          errors = 0;
    int          exp_pkt = 0;
    exp_hdr_t    hq[$];
    logic [1:0]  eq[$];
    logic [7:0]  pkt[$];

    assign hdr_ack = ack_drv | stray_ack;

    always #5 clk = ~clk;

    ipv4_hdr_capture dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_sop    (rx_sop),
        .rx_eop    (rx_eop),
        .rx_ready  (rx_ready),
        .ih1       (ih1),
        .ih2       (ih2),
        .ih3       (ih3),
        .ih4       (ih4),
        .ih5       (ih5),
        .ih6       (ih6),
        .hdr_ihl   (hdr_ihl),
        .hdr_valid (hdr_valid),
        .hdr_ack   (hdr_ack),
        .hdr_err   (hdr_err),
        .err_code  (err_code),
        .pkt_count (pkt_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic s, input logic e);
        int n = 0;
        @(negedge clk);
        rx_data = d; rx_valid = 1'b1; rx_sop = s; rx_eop = e;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL rx_ready_timeout actual=0 expected=1");
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
    endtask

    task automatic add_word(input logic [31:0] w);
        pkt.push_back(w[31:24]); pkt.push_back(w[23:16]);
        pkt.push_back(w[15:8]);  pkt.push_back(w[7:0]);
    endtask

    task automatic send_pkt(input logic first_sop, input logic last_eop);
        for (int i = 0; i < pkt.size(); i++) begin
            send(pkt[i], first_sop && (i == 0), last_eop && (i == pkt.size() - 1));
        end
        pkt.delete();
    endtask

    task automatic push_hdr(input logic [3:0] ihl, input logic [31:0] w1, w2, w3, w4, w5, w6);
        exp_hdr_t e;
        e.ihl = ihl;
        e.w[0] = w1; e.w[1] = w2; e.w[2] = w3; e.w[3] = w4; e.w[4] = w5; e.w[5] = w6;
        hq.push_back(e);
    endtask

    task automatic add_p1_hdr();
        add_word(32'h45000073); add_word(32'h00004000); add_word(32'h40110000);
        add_word(32'hC0A80001); add_word(32'hC0A800C7);
    endtask

    task automatic push_p1();
        push_hdr(4'd5, 32'h45000073, 32'h00004000, 32'h40110000, 32'hC0A80001, 32'hC0A800C7, 32'h0);
    endtask

    // Headers accepted by the consumer, counted at the accepting edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_pkt <= 0;
        end else if (hdr_valid && hdr_ack) begin
            exp_pkt <= exp_pkt + 1;
        end
    end

    // Consumer model: acknowledges after ack_delay cycles of hdr_valid.
    initial begin
        forever begin
            @(negedge clk);
            if (hdr_valid && !ack_drv) begin
                if (ack_cnt >= ack_delay) ack_drv = 1'b1;
                else ack_cnt++;
            end else begin
                ack_drv = 1'b0;
                ack_cnt = 0;
            end
        end
    end

    // Scoreboard monitor.
    initial begin : monitor
        logic             prev_v;
        exp_hdr_t         cur;
        logic [5:0][31:0] snap;
        prev_v = 1'b0;
        snap = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (hdr_valid && !prev_v) begin
                    if (hq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_hdr_valid actual=%0h expected=none", ih1);
                    end else begin
                        cur = hq.pop_front();
                        chk("ih1", ih1, cur.w[0]); chk("ih2", ih2, cur.w[1]);
                        chk("ih3", ih3, cur.w[2]); chk("ih4", ih4, cur.w[3]);
                        chk("ih5", ih5, cur.w[4]); chk("ih6", ih6, cur.w[5]);
                        chk("hdr_ihl", {28'd0, hdr_ihl}, {28'd0, cur.ihl});
                    end
                    snap = {ih6, ih5, ih4, ih3, ih2, ih1};
                end else if (hdr_valid) begin
                    checks++;
                    if ({ih6, ih5, ih4, ih3, ih2, ih1} !== snap) begin
                        errors++;
                        $display("FAIL hold_stable actual=%0h expected=%0h", ih1, snap[0]);
                    end
                    chk("hold_rx_ready", {31'd0, rx_ready}, 32'd0);
                end
                if (hdr_err) begin
                    if (eq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_hdr_err actual=%0d expected=none", err_code);
                    end else begin
                        chk("err_code", {30'd0, err_code}, {30'd0, eq.pop_front()});
                    end
                end
                chk("pkt_count", {16'd0, pkt_count}, 32'(exp_pkt));
            end
            prev_v = hdr_valid;
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        chk({tag, "_ih1"}, ih1, 32'd0);
        chk({tag, "_ih6"}, ih6, 32'd0);
        chk({tag, "_hdr_ihl"}, {28'd0, hdr_ihl}, 32'd0);
        chk({tag, "_hdr_valid"}, {31'd0, hdr_valid}, 32'd0);
        chk({tag, "_err_code"}, {30'd0, err_code}, 32'd0);
        chk({tag, "_pkt_count"}, {16'd0, pkt_count}, 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rx_ready_after_reset", {31'd0, rx_ready}, 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        release_reset();

        // Basic IHL=5 header with payload, consumer holds off for 10 cycles.
        ack_delay = 10;
        push_p1();
        add_p1_hdr();
        void'(pkt.pop_back());
        send_pkt(1'b1, 1'b0);
        chk("latency_pre", {31'd0, hdr_valid}, 32'd0);
        send(8'hC7, 1'b0, 1'b0);
        chk("latency", {31'd0, hdr_valid}, 32'd1);
        send(8'hAA, 1'b0, 1'b0);
        send(8'hBB, 1'b0, 1'b0);
        send(8'hCC, 1'b0, 1'b1);
        chk("p1_count", {16'd0, pkt_count}, 32'd1);

        // IHL=6 header ending on eop.
        ack_delay = 0;
        push_hdr(4'd6, 32'h46000020, 32'h12340000, 32'h40060000, 32'h0A000001, 32'h0A000002, 32'h01020304);
        add_word(32'h46000020); add_word(32'h12340000); add_word(32'h40060000);
        add_word(32'h0A000001); add_word(32'h0A000002); add_word(32'h01020304);
        send_pkt(1'b1, 1'b1);

        // IHL=5 after IHL=6: option word must read back as zero.
        push_p1();
        add_p1_hdr();
        send_pkt(1'b1, 1'b1);

        // Error packets.
        eq.push_back(2'd1);
        add_word(32'h65000014); pkt.push_back(8'h00);
        send_pkt(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        chk("err_code_held_ver", {30'd0, err_code}, 32'd1);
        eq.push_back(2'd2);
        add_word(32'h47000018);
        send_pkt(1'b1, 1'b1);
        eq.push_back(2'd3);
        add_word(32'h45000010); pkt.push_back(8'h11); pkt.push_back(8'h22);
        send_pkt(1'b1, 1'b1);
        eq.push_back(2'd3);
        add_word(32'h45000040); add_word(32'h00000000); add_word(32'h40110000);
        send_pkt(1'b1, 1'b1);
        eq.push_back(2'd3);
        send(8'h45, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        chk("err_code_held_runt", {30'd0, err_code}, 32'd3);

        // Restart mid-header with a new sop: no error, full header delivered.
        push_p1();
        add_word(32'h45000073); add_word(32'h00004000);
        send_pkt(1'b1, 1'b0);
        add_p1_hdr();
        send_pkt(1'b1, 1'b1);

        // hdr_ack without hdr_valid must not count.
        repeat (3) @(negedge clk);
        stray_ack = 1'b1;
        repeat (3) @(negedge clk);
        stray_ack = 1'b0;
        chk("count_before_reset", {16'd0, pkt_count}, 32'd4);

        // Asynchronous reset while holding a header.
        ack_delay = 1000;
        push_hdr(4'd6, 32'h46000020, 32'h12340000, 32'h40060000, 32'h0A000001, 32'h0A000002, 32'h01020304);
        add_word(32'h46000020); add_word(32'h12340000); add_word(32'h40060000);
        add_word(32'h0A000001); add_word(32'h0A000002); add_word(32'h01020304);
        send_pkt(1'b1, 1'b1);
        chk("hold_before_reset", {31'd0, hdr_valid}, 32'd1);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("reset_hold");
        ack_delay = 0;
        release_reset();

        // Asynchronous reset part-way through a header.
        push_p1();
        add_p1_hdr();
        send_pkt(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        chk("count_before_hdr_reset", {16'd0, pkt_count}, 32'd1);
        send(8'h45, 1'b1, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        send(8'h73, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("reset_hdr");
        release_reset();

        repeat (5) @(negedge clk);
        chk("hdr_queue_empty", 32'(hq.size()), 32'd0);
        chk("err_queue_empty", 32'(eq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
